// File: rtl/blur_pkg.sv
// blur_pkg: shared widths, kernel weights and arithmetic helpers for the 3x3 blur
package blur_pkg;
  localparam int PIX_W = 8;
  localparam int ROW_W = 10;
  localparam int SUM_W = 12;
  localparam int K_EDGE = 1;
  localparam int K_NEAR = 2;
  localparam int ROUND = 8;
  localparam int SHIFT = 4;
  localparam int PIPE_DEPTH = 3;
  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [ROW_W-1:0] row_t;
  typedef logic [SUM_W-1:0] sum_t;
  typedef struct packed {
    logic valid;
    logic line_start;
    logic frame_start;
    logic pass;
  } ctl_t;
  function automatic row_t row_sum(input pix_t a, input pix_t b, input pix_t c);
    return row_t'(a) * row_t'(K_EDGE) + row_t'(b) * row_t'(K_NEAR) + row_t'(c) * row_t'(K_EDGE);
  endfunction
  function automatic pix_t round_shift(input sum_t s);
    return pix_t'((s + sum_t'(ROUND)) >> SHIFT);
  endfunction
endpackage

// File: rtl/pixel_blur_3x3_if.sv
// pixel_blur_3x3_if: tap/strobe inputs and filtered pixel outputs of the blur
interface pixel_blur_3x3_if;
  import blur_pkg::*;
  pix_t tap_top, tap_mid, tap_bot, pixel_out;
  logic valid_in, line_start, frame_start, blur_en;
  logic valid_out, line_start_out, frame_start_out;
  modport master(
    output tap_top, tap_mid, tap_bot, valid_in, line_start, frame_start, blur_en,
    input pixel_out, valid_out, line_start_out, frame_start_out
  );
  modport slave(
    input tap_top, tap_mid, tap_bot, valid_in, line_start, frame_start, blur_en,
    output pixel_out, valid_out, line_start_out, frame_start_out
  );
endinterface

// File: rtl/blur_window_3x3.sv
// blur_window_3x3: three 3-deep column shift registers that advance only on active pixels
module blur_window_3x3 import blur_pkg::*; (
  input logic clock,
  input logic reset_n,
  input logic shift,
  input pix_t tap_top,
  input pix_t tap_mid,
  input pix_t tap_bot,
  output pix_t [2:0][2:0] win
);
  // rows 0/1/2 are top/mid/bot, column 0 holds the newest sample; gaps hold contents
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) win <= '0;
    else if (shift) win <= {win[2][1:0], tap_bot, win[1][1:0], tap_mid, win[0][1:0], tap_top};
endmodule

// File: rtl/pixel_blur_3x3.sv
// pixel_blur_3x3: pipelined [1 2 1;2 4 2;1 2 1]/16 blur with edge and bypass pass-through
module pixel_blur_3x3 import blur_pkg::*; #(
  parameter int H_PIXELS = 1280,
  parameter int V_LINES = 1024
) (
  input logic clock,
  input logic reset_n,
  pixel_blur_3x3_if.slave bus
);
  localparam int CW = $clog2(H_PIXELS + 1);
  localparam int RW = $clog2(V_LINES + 1);
  pix_t [2:0][2:0] win;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic on_edge;
  ctl_t [PIPE_DEPTH-1:0] ctl;
  row_t sum_top, sum_mid, sum_bot;
  sum_t total;
  pix_t centre1, centre2;
  blur_window_3x3 u_window (
    .clock(clock),
    .reset_n(reset_n),
    .shift(bus.valid_in),
    .tap_top(bus.tap_top),
    .tap_mid(bus.tap_mid),
    .tap_bot(bus.tap_bot),
    .win(win)
  );
  // a strobe on this pixel means the counters are restarting, so the window straddles an edge
  assign on_edge = bus.line_start | bus.frame_start | (col < CW'(2)) | (row < RW'(2));
  // column position within the line, restarted by line_start and saturating at the line width
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) col <= '0;
    else if (bus.valid_in) col <= bus.line_start ? CW'(1) : (col == CW'(H_PIXELS) ? col : col + 1'b1);
  // line index within the frame; frame_start wins over a coincident line_start
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) row <= '0;
    else if (bus.valid_in && bus.frame_start) row <= '0;
    else if (bus.valid_in && bus.line_start && row != RW'(V_LINES)) row <= row + 1'b1;
  // control bits travel beside the data; stage 0 is captured on the window-shift edge
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) ctl <= '0;
    else ctl <= {ctl[PIPE_DEPTH-2:0], ctl_t'{bus.valid_in, bus.valid_in & bus.line_start,
                                            bus.valid_in & bus.frame_start, ~bus.blur_en | on_edge}};
  // stage 1: horizontal weighted sums of each window row
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      sum_top <= '0;
      sum_mid <= '0;
      sum_bot <= '0;
      centre1 <= '0;
    end else begin
      sum_top <= row_sum(win[0][0], win[0][1], win[0][2]);
      sum_mid <= row_sum(win[1][0], win[1][1], win[1][2]);
      sum_bot <= row_sum(win[2][0], win[2][1], win[2][2]);
      centre1 <= win[1][1];
    end
  // stage 2: vertical weighting into the full 12-bit kernel total
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      total <= '0;
      centre2 <= '0;
    end else begin
      total <= sum_t'(sum_top) * sum_t'(K_EDGE) + sum_t'(sum_mid) * sum_t'(K_NEAR) + sum_t'(sum_bot) * sum_t'(K_EDGE);
      centre2 <= centre1;
    end
  // stage 3: rounded divide by 16 or the untouched centre; pixel_out holds between valid pixels
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      bus.pixel_out <= '0;
      bus.valid_out <= 1'b0;
      bus.line_start_out <= 1'b0;
      bus.frame_start_out <= 1'b0;
    end else begin
      if (ctl[PIPE_DEPTH-1].valid) bus.pixel_out <= ctl[PIPE_DEPTH-1].pass ? centre2 : round_shift(total);
      bus.valid_out <= ctl[PIPE_DEPTH-1].valid;
      bus.line_start_out <= ctl[PIPE_DEPTH-1].line_start;
      bus.frame_start_out <= ctl[PIPE_DEPTH-1].frame_start;
    end
endmodule

// File: tb/tb_pixel_blur_3x3.sv
// tb_pixel_blur_3x3: directed scenarios with hand-computed blur outputs
module tb_pixel_blur_3x3;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  typedef struct {
    logic [7:0] p;
    logic ls;
    logic fs;
    int c;
  } obs_t;
  obs_t got[$];

  pixel_blur_3x3_if bus();
  pixel_blur_3x3 #(.H_PIXELS(16), .V_LINES(8)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock)
    if (bus.valid_out === 1'b1) got.push_back('{bus.pixel_out, bus.line_start_out, bus.frame_start_out, cyc});

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic pix(input logic [7:0] t, input logic [7:0] m, input logic [7:0] b,
                     input logic ls = 1'b0, input logic fs = 1'b0, input logic en = 1'b1);
    @(negedge clock);
    bus.tap_top = t;
    bus.tap_mid = m;
    bus.tap_bot = b;
    bus.valid_in = 1'b1;
    bus.line_start = ls;
    bus.frame_start = fs;
    bus.blur_en = en;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      bus.valid_in = 1'b0;
      bus.line_start = 1'b0;
      bus.frame_start = 1'b0;
    end
  endtask

  // new frame of zeros, leaving row=2 col=2 so the next pixel is filtered
  task automatic prime();
    pix(0, 0, 0, 1, 1);
    pix(0, 0, 0, 1);
    pix(0, 0, 0, 1);
    pix(0, 0, 0);
    idle(6);
    got.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    total++; if (bus.pixel_out !== 8'd0) begin bad++; $display("FAIL reset_pixel got=%0d want=0", bus.pixel_out); end
    total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.valid_out); end
    total++; if (bus.line_start_out !== 1'b0) begin bad++; $display("FAIL reset_ls got=%b want=0", bus.line_start_out); end
    total++; if (bus.frame_start_out !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b want=0", bus.frame_start_out); end
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_flat();
    logic [7:0] e[5] = '{25, 75, 100, 100, 100};
    int s0 = 0;
    prime();
    for (int i = 0; i < 5; i++) begin
      pix(100, 100, 100);
      if (i == 0) s0 = cyc + 1;
    end
    idle(6);
    total++; if (got.size() !== 5) begin bad++; $display("FAIL flat_count got=%0d want=5", got.size()); end
    for (int i = 0; i < 5; i++) begin
      total++; if (got[i].p !== e[i]) begin bad++; $display("FAIL flat_%0d got=%0d want=%0d", i, got[i].p, e[i]); end
    end
    total++; if (got[0].c !== s0 + 3) begin bad++; $display("FAIL flat_latency got=%0d want=%0d", got[0].c - s0, 3); end
  endtask

  task automatic test_impulse();
    logic [7:0] t[5] = '{0, 0, 255, 0, 0};
    logic [7:0] m[5] = '{255, 0, 0, 0, 0};
    logic [7:0] e[5] = '{32, 64, 48, 32, 16};
    prime();
    for (int i = 0; i < 5; i++) pix(t[i], m[i], 0);
    idle(6);
    total++; if (got.size() !== 5) begin bad++; $display("FAIL impulse_count got=%0d want=5", got.size()); end
    for (int i = 0; i < 5; i++) begin
      total++; if (got[i].p !== e[i]) begin bad++; $display("FAIL impulse_%0d got=%0d want=%0d", i, got[i].p, e[i]); end
    end
  endtask

  task automatic test_extremes();
    logic [7:0] e[7] = '{64, 191, 255, 255, 191, 64, 0};
    prime();
    for (int i = 0; i < 7; i++) pix(i < 4 ? 8'd255 : 8'd0, i < 4 ? 8'd255 : 8'd0, i < 4 ? 8'd255 : 8'd0);
    idle(6);
    total++; if (got.size() !== 7) begin bad++; $display("FAIL extreme_count got=%0d want=7", got.size()); end
    for (int i = 0; i < 7; i++) begin
      total++; if (got[i].p !== e[i]) begin bad++; $display("FAIL extreme_%0d got=%0d want=%0d", i, got[i].p, e[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] t[5] = '{0, 0, 255, 0, 0};
    logic [7:0] m[5] = '{255, 0, 0, 0, 0};
    logic [7:0] e[5] = '{32, 64, 48, 32, 16};
    prime();
    for (int i = 0; i < 5; i++) begin
      pix(t[i], m[i], 0);
      idle(2);
    end
    idle(6);
    total++; if (got.size() !== 5) begin bad++; $display("FAIL gap_count got=%0d want=5", got.size()); end
    for (int i = 0; i < 5; i++) begin
      total++; if (got[i].p !== e[i]) begin bad++; $display("FAIL gap_%0d got=%0d want=%0d", i, got[i].p, e[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      total++; if (got[i+1].c - got[i].c !== 3) begin bad++; $display("FAIL gap_spacing_%0d got=%0d want=3", i, got[i+1].c - got[i].c); end
    end
  endtask

  task automatic test_edge();
    pix(200, 50, 200);
    idle(6);
    got.delete();
    for (int l = 0; l < 3; l++)
      for (int i = 0; i < 4; i++) pix(200, 50, 200, i == 0, l == 0 && i == 0);
    idle(6);
    total++; if (got.size() !== 12) begin bad++; $display("FAIL edge_count got=%0d want=12", got.size()); end
    for (int i = 0; i < 12; i++) begin
      total++;
      if (got[i].p !== (i >= 10 ? 8'd125 : 8'd50)) begin
        bad++; $display("FAIL edge_%0d got=%0d want=%0d", i, got[i].p, i >= 10 ? 125 : 50);
      end
    end
    total++; if (got[0].fs !== 1'b1) begin bad++; $display("FAIL edge_fs0 got=%b want=1", got[0].fs); end
    total++; if (got[0].ls !== 1'b1) begin bad++; $display("FAIL edge_ls0 got=%b want=1", got[0].ls); end
    total++; if (got[1].ls !== 1'b0) begin bad++; $display("FAIL edge_ls1 got=%b want=0", got[1].ls); end
    total++; if (got[4].ls !== 1'b1) begin bad++; $display("FAIL edge_ls4 got=%b want=1", got[4].ls); end
    total++; if (got[4].fs !== 1'b0) begin bad++; $display("FAIL edge_fs4 got=%b want=0", got[4].fs); end
    total++; if (got[8].ls !== 1'b1) begin bad++; $display("FAIL edge_ls8 got=%b want=1", got[8].ls); end
  endtask

  task automatic test_blur_off();
    logic [7:0] e[4] = '{0, 50, 50, 125};
    prime();
    for (int i = 0; i < 4; i++) pix(200, 50, 200, 0, 0, i == 3);
    idle(6);
    total++; if (got.size() !== 4) begin bad++; $display("FAIL bypass_count got=%0d want=4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      total++; if (got[i].p !== e[i]) begin bad++; $display("FAIL bypass_%0d got=%0d want=%0d", i, got[i].p, e[i]); end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] e[4] = '{0, 50, 50, 50};
    prime();
    for (int i = 0; i < 5; i++) pix(100, 100, 100);
    #2;
    total++; if (bus.valid_out !== 1'b1) begin bad++; $display("FAIL arst_pre_valid got=%b want=1", bus.valid_out); end
    reset_n = 1'b0;
    got.delete();
    #1;
    total++; if (bus.pixel_out !== 8'd0) begin bad++; $display("FAIL arst_pixel got=%0d want=0", bus.pixel_out); end
    total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b want=0", bus.valid_out); end
    bus.valid_in = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    idle(5);
    total++; if (got.size() !== 0) begin bad++; $display("FAIL arst_quiet got=%0d want=0", got.size()); end
    for (int i = 0; i < 4; i++) pix(200, 50, 200);
    idle(6);
    total++; if (got.size() !== 4) begin bad++; $display("FAIL arst_count got=%0d want=4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      total++; if (got[i].p !== e[i]) begin bad++; $display("FAIL arst_%0d got=%0d want=%0d", i, got[i].p, e[i]); end
    end
  endtask

  initial begin
    bus.tap_top = '0;
    bus.tap_mid = '0;
    bus.tap_bot = '0;
    bus.valid_in = 1'b0;
    bus.line_start = 1'b0;
    bus.frame_start = 1'b0;
    bus.blur_en = 1'b1;
    test_reset();
    test_flat();
    test_impulse();
    test_extremes();
    test_back_to_back();
    test_edge();
    test_blur_off();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pixel_blur_3x3.md
PIXEL_BLUR_3X3 -- requirements
Module: pixel_blur_3x3

Interface
REQ-001 Parameter H_PIXELS, default 1280, active pixels per line (column counter range).
REQ-002 Parameter V_LINES, default 1024, active lines per frame (row counter range).
REQ-003 clock  input  1  single clock for all logic; rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 tap_top  input  8  oldest row sample (output of second chained line shift register).
REQ-006 tap_mid  input  8  middle row sample (output of first line shift register).
REQ-007 tap_bot  input  8  newest row sample (current incoming pixel).
REQ-008 valid_in  input  1  taps carry an active pixel this cycle.
REQ-009 line_start  input  1  pulse coincident with first valid_in of each line.
REQ-010 frame_start  input  1  pulse coincident with first line_start of each frame.
REQ-011 blur_en  input  1  1 = apply kernel, 0 = pass centre tap.
REQ-012 pixel_out  output  8  filtered pixel.
REQ-013 valid_out  output  1  pixel_out valid.
REQ-014 line_start_out, frame_start_out  output  1 each  input strobes delayed to align with pixel_out.

Function
REQ-015 Window: three 3-deep column shift registers (one per row) SHALL shift only on cycles with valid_in=1; gaps hold contents.
REQ-016 Kernel SHALL be [1 2 1; 2 4 2; 1 2 1], centre = middle element of the mid-row register chain.
REQ-017 Stage 1 (cycle after sample): row sums a+2b+c, 10 bits unsigned each.
REQ-018 Stage 2: total = top + 2*mid + bot, 12 bits; no truncation before this point.
REQ-019 Stage 3: pixel_out = (total + 8) >> 4; maximum 4088>>4 = 255, no saturation logic needed.
REQ-020 Latency: valid_out, line_start_out, frame_start_out SHALL equal valid_in, line_start, frame_start delayed exactly 3 cycles after the window-shift edge, independent of gaps.
REQ-021 Column counter: cleared to 1 on valid_in with line_start, else +1 per valid_in, saturating at H_PIXELS.
REQ-022 Row counter: cleared to 0 on frame_start, +1 per line_start, saturating at V_LINES.
REQ-023 Edge rule: when column counter <2 or row counter <2 at the shift edge, output SHALL be the centre tap (unfiltered) through the same 3-cycle pipeline.
REQ-024 blur_en=0 SHALL output the centre tap with identical latency; blur_en sampled with the window shift, so a change affects exactly the pixels shifted in after it.
REQ-025 line_start and frame_start without valid_in SHALL be ignored (counters unchanged).
REQ-026 Simultaneous frame_start and line_start: row counter cleared to 0 (frame_start wins), then counts from the next line_start.

Reset
REQ-027 reset_n low SHALL immediately clear all window registers, pipeline registers, counters, pixel_out=0, valid_out=0, strobe outputs=0.
REQ-028 Reset mid-line: in-flight pixels discarded; after release no valid_out until valid_in seen, and edge rule applies until next frame_start/line_start resynchronises counters.

Structure
REQ-029 Shared package blur_pkg SHALL hold PIX_W=8, SUM_W=12, kernel weights, ROUND=8, SHIFT=4, pipeline depth 3.
REQ-030 One sub-module blur_window_3x3 SHALL hold the 9 window registers and shift enable; arithmetic and counters stay in the top.

Verification
REQ-031 Flat field 100 on all taps, blur_en=1, past edges -> pixel_out=100, valid_out 3 cycles after valid_in.
REQ-032 Single bright pixel 255 in centre, zeros elsewhere, row>=2 col>=2 -> centre output (1020+8)>>4=64, horizontal neighbour output (510+8)>>4=32, diagonal (255+8)>>4=16.
REQ-033 All taps 255 -> output 255, no wrap; all 0 -> 0.
REQ-034 Stream with valid_in gaps (1 on, 2 off) -> outputs identical to gap-free run, valid_out pattern shifted 3 cycles.
REQ-035 First two pixels of line and first two lines of frame with centre 50, neighbours 200 -> output 50 (edge pass-through); blur_en=0 anywhere -> centre tap.
REQ-036 reset_n asserted mid-line with valid pipeline -> pixel_out=0, valid_out=0 same cycle asynchronously; counters 0.
